// File: rtl/jtdd_rom_arb_pkg.sv
// Shared constants and helpers for the char/scroll/object ROM arbiter.
// FSM state encodings, slot identifiers and default SDRAM offsets live here.
package jtdd_rom_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE      = 2'd0;
    localparam state_t WAIT_ACK  = 2'd1;
    localparam state_t WAIT_DATA = 2'd2;

    localparam logic [1:0] SLOT_CHAR = 2'd0;
    localparam logic [1:0] SLOT_SCR  = 2'd1;
    localparam logic [1:0] SLOT_OBJ  = 2'd2;

    localparam logic [21:0] DEF_CHAR_OFFSET = 22'h00_0000;
    localparam logic [21:0] DEF_SCR_OFFSET  = 22'h01_0000;
    localparam logic [21:0] DEF_OBJ_OFFSET  = 22'h03_0000;

    function automatic logic [1:0] next_slot(input logic [1:0] s);
        return (s == SLOT_OBJ) ? SLOT_CHAR : s + 2'd1;
    endfunction

    // First pending slot at or after rr, wrapping obj -> char.
    function automatic logic [1:0] pick_slot(input logic [2:0] pend, input logic [1:0] rr);
        logic [1:0] s;
        logic [1:0] pick;
        logic       found;
        s     = rr;
        pick  = rr;
        found = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (!found && pend[s]) begin
                pick  = s;
                found = 1'b1;
            end
            s = next_slot(s);
        end
        return pick;
    endfunction

endpackage

// File: rtl/jtdd_rom_arb_slot.sv
// One ROM fetcher slot: remembers the last served address and its data.
// With DW=8 the slot stores the byte picked by bit 0 of the served address.
module jtdd_rom_arb_slot
    import jtdd_rom_arb_pkg::*;
#(
    parameter int unsigned AW = 15,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic          wr,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   din,
    output logic [DW-1:0] data,
    output logic          ok,
    output logic          pending
);

    logic [AW-1:0] last_addr;
    logic          valid;
    logic [DW-1:0] din_sel;

    generate
        if (DW == 8) begin : g_byte
            assign din_sel = wr_addr[0] ? din[15:8] : din[7:0];
        end else begin : g_word
            assign din_sel = din[DW-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            last_addr <= '0;
            valid     <= 1'b0;
            data      <= '0;
        end else if (wr) begin
            // Stored even if addr moved on meanwhile; ok then stays low.
            last_addr <= wr_addr;
            valid     <= 1'b1;
            data      <= din_sel;
        end
    end

    always_comb begin
        ok      = valid && (addr == last_addr);
        pending = !ok;
    end

endmodule

// File: rtl/jtdd_rom_arb.sv
// Round-robin arbiter sharing one SDRAM read port between char, scroll and object ROM fetchers.
// Define JTDD_ROMARB_TIMEOUT_EN to reissue a read when data_rdy never arrives.
module jtdd_rom_arb
    import jtdd_rom_arb_pkg::*;
#(
    parameter logic [21:0] CHAR_OFFSET = DEF_CHAR_OFFSET,
    parameter logic [21:0] SCR_OFFSET  = DEF_SCR_OFFSET,
    parameter logic [21:0] OBJ_OFFSET  = DEF_OBJ_OFFSET
`ifdef JTDD_ROMARB_TIMEOUT_EN
    ,
    parameter logic [7:0]  TIMEOUT     = 8'd63
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [14:0] char_addr,
    output logic [7:0]  char_data,
    output logic        char_ok,
    input  logic [16:0] scr_addr,
    output logic [15:0] scr_data,
    output logic        scr_ok,
    input  logic [17:0] obj_addr,
    output logic [15:0] obj_data,
    output logic        obj_ok,
    output logic [21:0] sdram_addr,
    output logic        sdram_req,
    input  logic        sdram_ack,
    input  logic        data_rdy,
    input  logic [15:0] data_read
);

    state_t      state;
    logic [1:0]  rr;
    logic [1:0]  slot;
    logic [17:0] snap;

    logic [2:0]  pend;
    logic [1:0]  sel;
    logic [17:0] sel_addr;
    logic [21:0] sel_map;
    logic        wr_char;
    logic        wr_scr;
    logic        wr_obj;
    logic        pend_char;
    logic        pend_scr;
    logic        pend_obj;

`ifdef JTDD_ROMARB_TIMEOUT_EN
    logic [7:0]  cnt;
    logic [7:0]  cnt_nxt;
    assign cnt_nxt = cnt + 8'd1;
`endif

    jtdd_rom_arb_slot #(
        .AW (15),
        .DW (8)
    ) u_char (
        .clk     (clk),
        .rst     (rst),
        .addr    (char_addr),
        .wr      (wr_char),
        .wr_addr (snap[14:0]),
        .din     (data_read),
        .data    (char_data),
        .ok      (char_ok),
        .pending (pend_char)
    );

    jtdd_rom_arb_slot #(
        .AW (17),
        .DW (16)
    ) u_scr (
        .clk     (clk),
        .rst     (rst),
        .addr    (scr_addr),
        .wr      (wr_scr),
        .wr_addr (snap[16:0]),
        .din     (data_read),
        .data    (scr_data),
        .ok      (scr_ok),
        .pending (pend_scr)
    );

    jtdd_rom_arb_slot #(
        .AW (18),
        .DW (16)
    ) u_obj (
        .clk     (clk),
        .rst     (rst),
        .addr    (obj_addr),
        .wr      (wr_obj),
        .wr_addr (snap),
        .din     (data_read),
        .data    (obj_data),
        .ok      (obj_ok),
        .pending (pend_obj)
    );

    always_comb begin
        pend    = {pend_obj, pend_scr, pend_char};
        sel     = pick_slot(pend, rr);
        wr_char = (state == WAIT_DATA) && data_rdy && (slot == SLOT_CHAR);
        wr_scr  = (state == WAIT_DATA) && data_rdy && (slot == SLOT_SCR);
        wr_obj  = (state == WAIT_DATA) && data_rdy && (slot == SLOT_OBJ);
        case (sel)
            SLOT_CHAR: begin
                sel_addr = {3'd0, char_addr};
                sel_map  = CHAR_OFFSET + {8'd0, char_addr[14:1]};
            end
            SLOT_SCR: begin
                sel_addr = {1'b0, scr_addr};
                sel_map  = SCR_OFFSET + {5'd0, scr_addr};
            end
            default: begin
                sel_addr = obj_addr;
                sel_map  = OBJ_OFFSET + {4'd0, obj_addr};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr         <= SLOT_CHAR;
            slot       <= SLOT_CHAR;
            snap       <= '0;
            sdram_addr <= '0;
            sdram_req  <= 1'b0;
`ifdef JTDD_ROMARB_TIMEOUT_EN
            cnt        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|pend) begin
                        slot       <= sel;
                        snap       <= sel_addr;
                        sdram_addr <= sel_map;
                        sdram_req  <= 1'b1;
                        state      <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        state     <= WAIT_DATA;
`ifdef JTDD_ROMARB_TIMEOUT_EN
                        cnt       <= '0;
`endif
                    end
                end
                WAIT_DATA: begin
                    if (data_rdy) begin
                        rr    <= next_slot(slot);
                        state <= IDLE;
                    end
`ifdef JTDD_ROMARB_TIMEOUT_EN
                    // Give up silently: slot stays pending and rr is untouched.
                    else begin
                        cnt <= cnt_nxt;
                        if (cnt_nxt == TIMEOUT) begin
                            state <= IDLE;
                        end
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtdd_rom_arb.sv
// Directed bench for jtdd_rom_arb: SDRAM responses are driven by hand, expectations hand-computed.
module tb_jtdd_rom_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] char_addr;
    logic [7:0]  char_data;
    logic        char_ok;
    logic [16:0] scr_addr;
    logic [15:0] scr_data;
    logic        scr_ok;
    logic [17:0] obj_addr;
    logic [15:0] obj_data;
    logic        obj_ok;
    logic [21:0] sdram_addr;
    logic        sdram_req;
    logic        sdram_ack;
    logic        data_rdy;
    logic [15:0] data_read;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    jtdd_rom_arb dut (
        .clk        (clk),
        .rst        (rst),
        .char_addr  (char_addr),
        .char_data  (char_data),
        .char_ok    (char_ok),
        .scr_addr   (scr_addr),
        .scr_data   (scr_data),
        .scr_ok     (scr_ok),
        .obj_addr   (obj_addr),
        .obj_data   (obj_data),
        .obj_ok     (obj_ok),
        .sdram_addr (sdram_addr),
        .sdram_req  (sdram_req),
        .sdram_ack  (sdram_ack),
        .data_rdy   (data_rdy),
        .data_read  (data_read)
    );

    // Waits (bounded) at negedges for sdram_req.
    task automatic wait_req(output bit tmo);
        int n;
        n   = 0;
        tmo = 1'b0;
        while (sdram_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sdram_req !== 1'b1) tmo = 1'b1;
    endtask

    // Acts as the SDRAM for one read; reports address seen and whether req/addr held.
    task automatic serve(input logic [15:0] rd, input int ack_dly,
                         output logic [21:0] got, output bit held, output bit tmo);
        held = 1'b1;
        got  = '0;
        wait_req(tmo);
        if (tmo) return;
        got = sdram_addr;
        repeat (ack_dly) begin
            @(negedge clk);
            if (sdram_req !== 1'b1 || sdram_addr !== got) held = 1'b0;
        end
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        if (sdram_req !== 1'b0) held = 1'b0;
        data_read = rd;
        data_rdy  = 1'b1;
        @(negedge clk);
        data_rdy  = 1'b0;
        data_read = '0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        data_read = '0;
        char_addr = 15'h0003;
        scr_addr  = 17'h00010;
        obj_addr  = 18'h000FF;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({char_ok, scr_ok, obj_ok} !== 3'b000) begin
            n_bad++; $display("FAIL reset_ok: got %b want 000", {char_ok, scr_ok, obj_ok});
        end
        n_cmp++;
        if ({char_data, scr_data, obj_data} !== 40'h0) begin
            n_bad++; $display("FAIL reset_data: got %h want 0", {char_data, scr_data, obj_data});
        end
        n_cmp++;
        if (sdram_req !== 1'b0 || sdram_addr !== 22'h0) begin
            n_bad++; $display("FAIL reset_sdram: got req=%b addr=%h want 0/0", sdram_req, sdram_addr);
        end
        rst = 1'b0;
    endtask

    task automatic test_first_round();
        logic [21:0] got;
        bit held, tmo;
        bit quiet;
        serve(16'hA55A, 0, got, held, tmo);
        n_cmp++;
        if (tmo || got !== 22'h000001) begin
            n_bad++; $display("FAIL char_addr_map: got %h tmo=%b want 000001", got, tmo);
        end
        n_cmp++;
        if (char_data !== 8'hA5 || char_ok !== 1'b1) begin
            n_bad++; $display("FAIL char_hi_byte: got %h ok=%b want A5 ok=1", char_data, char_ok);
        end
        serve(16'h1234, 0, got, held, tmo);
        n_cmp++;
        if (tmo || got !== 22'h010010) begin
            n_bad++; $display("FAIL scr_addr_map: got %h tmo=%b want 010010", got, tmo);
        end
        n_cmp++;
        if (scr_data !== 16'h1234 || scr_ok !== 1'b1) begin
            n_bad++; $display("FAIL scr_data: got %h ok=%b want 1234 ok=1", scr_data, scr_ok);
        end
        serve(16'hBEEF, 0, got, held, tmo);
        n_cmp++;
        if (tmo || got !== 22'h0300FF) begin
            n_bad++; $display("FAIL obj_addr_map: got %h tmo=%b want 0300FF", got, tmo);
        end
        n_cmp++;
        if (obj_data !== 16'hBEEF || obj_ok !== 1'b1) begin
            n_bad++; $display("FAIL obj_data: got %h ok=%b want BEEF ok=1", obj_data, obj_ok);
        end
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (sdram_req !== 1'b0) quiet = 1'b0;
        end
        n_cmp++;
        if (quiet !== 1'b1) begin
            n_bad++; $display("FAIL idle_quiet: got req activity want none");
        end
    endtask

    task automatic test_round_robin();
        logic [21:0] got;
        bit held, tmo;
        @(negedge clk);
        char_addr = 15'h0020;
        scr_addr  = 17'h00011;
        obj_addr  = 18'h00101;
        #1;
        n_cmp++;
        if ({char_ok, scr_ok, obj_ok} !== 3'b000) begin
            n_bad++; $display("FAIL rr_ok_drop: got %b want 000", {char_ok, scr_ok, obj_ok});
        end
        serve(16'h1122, 0, got, held, tmo);
        n_cmp++;
        if (tmo || got !== 22'h000010 || char_data !== 8'h22) begin
            n_bad++; $display("FAIL rr_first_char: got %h/%h want 000010/22", got, char_data);
        end
        serve(16'h3344, 0, got, held, tmo);
        n_cmp++;
        if (tmo || got !== 22'h010011 || scr_data !== 16'h3344) begin
            n_bad++; $display("FAIL rr_second_scr: got %h/%h want 010011/3344", got, scr_data);
        end
        serve(16'h5566, 0, got, held, tmo);
        n_cmp++;
        if (tmo || got !== 22'h030101 || obj_data !== 16'h5566) begin
            n_bad++; $display("FAIL rr_third_obj: got %h/%h want 030101/5566", got, obj_data);
        end
    endtask

    task automatic test_char_byte();
        logic [21:0] got;
        bit held, tmo;
        @(negedge clk);
        char_addr = 15'h0002;
        #1;
        n_cmp++;
        if (char_ok !== 1'b0) begin
            n_bad++; $display("FAIL char_ok_drop: got %b want 0", char_ok);
        end
        serve(16'hA55A, 0, got, held, tmo);
        n_cmp++;
        if (tmo || got !== 22'h000001) begin
            n_bad++; $display("FAIL char_reread: got %h want 000001", got);
        end
        n_cmp++;
        if (char_data !== 8'h5A || char_ok !== 1'b1) begin
            n_bad++; $display("FAIL char_lo_byte: got %h ok=%b want 5A ok=1", char_data, char_ok);
        end
    endtask

    // rr now points at scr; scr is idle so obj must come before char.
    task automatic test_wrap();
        logic [21:0] got;
        bit held, tmo;
        @(negedge clk);
        char_addr = 15'h0040;
        obj_addr  = 18'h00102;
        serve(16'h0077, 0, got, held, tmo);
        n_cmp++;
        if (tmo || got !== 22'h030102 || obj_data !== 16'h0077) begin
            n_bad++; $display("FAIL wrap_obj_first: got %h/%h want 030102/0077", got, obj_data);
        end
        serve(16'h0088, 0, got, held, tmo);
        n_cmp++;
        if (tmo || got !== 22'h000020 || char_data !== 8'h88) begin
            n_bad++; $display("FAIL wrap_char_next: got %h/%h want 000020/88", got, char_data);
        end
    endtask

    task automatic test_inflight();
        logic [21:0] got;
        bit held, tmo;
        @(negedge clk);
        obj_addr = 18'h00100;
        wait_req(tmo);
        n_cmp++;
        if (tmo || sdram_addr !== 22'h030100) begin
            n_bad++; $display("FAIL inflight_req: got %h tmo=%b want 030100", sdram_addr, tmo);
        end
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        obj_addr  = 18'h00200;
        data_read = 16'hAAAA;
        data_rdy  = 1'b1;
        @(negedge clk);
        data_rdy  = 1'b0;
        n_cmp++;
        if (obj_ok !== 1'b0 || obj_data !== 16'hAAAA) begin
            n_bad++; $display("FAIL inflight_stale: got ok=%b data=%h want ok=0 data=AAAA", obj_ok, obj_data);
        end
        serve(16'hBBBB, 0, got, held, tmo);
        n_cmp++;
        if (tmo || got !== 22'h030200) begin
            n_bad++; $display("FAIL inflight_reissue: got %h want 030200", got);
        end
        n_cmp++;
        if (obj_ok !== 1'b1 || obj_data !== 16'hBBBB) begin
            n_bad++; $display("FAIL inflight_final: got ok=%b data=%h want ok=1 data=BBBB", obj_ok, obj_data);
        end
    endtask

    task automatic test_delayed_ack();
        logic [21:0] got;
        bit held, tmo;
        @(negedge clk);
        scr_addr = 17'h00012;
        serve(16'h5A5A, 10, got, held, tmo);
        n_cmp++;
        if (tmo || got !== 22'h010012) begin
            n_bad++; $display("FAIL slow_ack_addr: got %h want 010012", got);
        end
        n_cmp++;
        if (held !== 1'b1) begin
            n_bad++; $display("FAIL slow_ack_hold: got held=%b want 1", held);
        end
        n_cmp++;
        if (scr_data !== 16'h5A5A || scr_ok !== 1'b1) begin
            n_bad++; $display("FAIL slow_ack_data: got %h ok=%b want 5A5A ok=1", scr_data, scr_ok);
        end
    endtask

    task automatic test_reset_midflight();
        logic [21:0] got;
        bit held, tmo;
        @(negedge clk);
        char_addr = 15'h0041;
        wait_req(tmo);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({char_ok, scr_ok, obj_ok} !== 3'b000 || sdram_req !== 1'b0) begin
            n_bad++; $display("FAIL midrst_ok: got ok=%b req=%b want 000/0", {char_ok, scr_ok, obj_ok}, sdram_req);
        end
        n_cmp++;
        if ({char_data, scr_data, obj_data} !== 40'h0) begin
            n_bad++; $display("FAIL midrst_data: got %h want 0", {char_data, scr_data, obj_data});
        end
        rst       = 1'b0;
        data_read = 16'hCCCC;
        data_rdy  = 1'b1;
        @(negedge clk);
        data_rdy  = 1'b0;
        data_read = '0;
        n_cmp++;
        if (char_ok !== 1'b0 || char_data !== 8'h00) begin
            n_bad++; $display("FAIL stray_rdy: got ok=%b data=%h want 0/00", char_ok, char_data);
        end
        n_cmp++;
        if (sdram_req !== 1'b1 || sdram_addr !== 22'h000020) begin
            n_bad++; $display("FAIL midrst_reissue: got req=%b addr=%h want 1/000020", sdram_req, sdram_addr);
        end
        serve(16'h1357, 0, got, held, tmo);
        n_cmp++;
        if (tmo || got !== 22'h000020 || char_data !== 8'h13) begin
            n_bad++; $display("FAIL midrst_char: got %h/%h want 000020/13", got, char_data);
        end
        serve(16'h2468, 0, got, held, tmo);
        n_cmp++;
        if (tmo || got !== 22'h010012 || scr_data !== 16'h2468) begin
            n_bad++; $display("FAIL midrst_scr: got %h/%h want 010012/2468", got, scr_data);
        end
        serve(16'h9ABC, 0, got, held, tmo);
        n_cmp++;
        if (tmo || got !== 22'h030200 || obj_data !== 16'h9ABC) begin
            n_bad++; $display("FAIL midrst_obj: got %h/%h want 030200/9ABC", got, obj_data);
        end
        n_cmp++;
        if ({char_ok, scr_ok, obj_ok} !== 3'b111) begin
            n_bad++; $display("FAIL midrst_all_ok: got %b want 111", {char_ok, scr_ok, obj_ok});
        end
    endtask

    // Without the timeout option WAIT_DATA never gives up.
    task automatic test_no_timeout();
        bit tmo;
        bit quiet;
        @(negedge clk);
        scr_addr = 17'h00013;
        wait_req(tmo);
        n_cmp++;
        if (tmo || sdram_addr !== 22'h010013) begin
            n_bad++; $display("FAIL notmo_req: got %h tmo=%b want 010013", sdram_addr, tmo);
        end
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        quiet = 1'b1;
        repeat (80) begin
            @(negedge clk);
            if (sdram_req !== 1'b0 || scr_ok !== 1'b0) quiet = 1'b0;
        end
        n_cmp++;
        if (quiet !== 1'b1) begin
            n_bad++; $display("FAIL notmo_wait: got reissue or ok want none");
        end
        data_read = 16'h0F0F;
        data_rdy  = 1'b1;
        @(negedge clk);
        data_rdy  = 1'b0;
        n_cmp++;
        if (scr_ok !== 1'b1 || scr_data !== 16'h0F0F) begin
            n_bad++; $display("FAIL notmo_late_data: got ok=%b data=%h want 1/0F0F", scr_ok, scr_data);
        end
    endtask

    initial begin
        test_reset();
        test_first_round();
        test_round_robin();
        test_char_byte();
        test_wrap();
        test_inflight();
        test_delayed_ack();
        test_reset_midflight();
        test_no_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
